d_ff_pet_reset_preset: RTL and testbench
========================================

D_FF_PET_RESET_PRESET -- requirements
Module: d_ff_pet_reset_preset

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the data width in bits (legal 1..64).
REQ-002 The block SHALL have parameter RESET_VAL, default all-zeros, giving the value loaded by reset.
REQ-003 The block SHALL have parameter PRESET_VAL, default all-ones, giving the value loaded by preset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port preset_in, input, 1 bit: preset, active-high.
REQ-007 The block SHALL have port en_in, input, 1 bit: data-load enable, active-high.
REQ-008 The block SHALL have port d_in, input, WIDTH bits: data to capture.
REQ-009 The block SHALL have port q_out, output, WIDTH bits: registered state.
REQ-010 The block SHALL have port qn_out, output, WIDTH bits: bitwise inverse of q_out.
REQ-011 The block SHALL have port chg_out, output, 1 bit: high for the cycle after any edge that changed q_out.

Function
REQ-012 Each rising clk edge SHALL update q_out by fixed priority: reset_in=1 -> RESET_VAL; else preset_in=1 -> PRESET_VAL; else en_in=1 -> d_in; else hold.
REQ-013 reset_in and preset_in both high SHALL yield RESET_VAL (reset wins).
REQ-014 Data latency SHALL be one clock: d_in sampled at edge N appears on q_out immediately after edge N.
REQ-015 d_in toggling between edges SHALL have no effect on q_out.
REQ-016 qn_out SHALL be combinational ~q_out at all times, with no extra register.
REQ-017 chg_out SHALL be registered: 1 after an edge where next q differs from previous q, else 0.
REQ-018 Preset asserted for multiple cycles SHALL hold PRESET_VAL; chg_out SHALL be 1 only on the first such cycle, when q actually changes.

Reset
REQ-019 Reset SHALL take effect only at a rising clk edge; asserting reset_in between edges SHALL leave q_out unchanged until the next edge.
REQ-020 After a reset edge, q_out SHALL equal RESET_VAL and qn_out SHALL equal ~RESET_VAL.
REQ-021 After a reset edge, chg_out SHALL equal 1 if q changed and 0 otherwise.
REQ-022 Reset asserted mid-operation SHALL override any pending data or preset at that edge.

Configuration
REQ-023 Macro ASYNC_PRESET_EN SHALL select the preset style.
REQ-024 With ASYNC_PRESET_EN undefined, preset SHALL be synchronous, as in REQ-012.
REQ-025 With ASYNC_PRESET_EN defined, preset_in rising SHALL force q_out to PRESET_VAL immediately, without waiting for a clk edge.
REQ-026 With ASYNC_PRESET_EN defined, q_out SHALL stay at PRESET_VAL while preset_in is high, except at a clk edge with reset_in=1, which SHALL load RESET_VAL.
REQ-027 With ASYNC_PRESET_EN defined, chg_out SHALL still be updated only on clk edges.

Structure
REQ-028 A shared package d_ff_pet_pkg SHALL hold the max-width constant and the default RESET_VAL and PRESET_VAL constants.
REQ-029 One sub-module d_ff_pet_cell (a 1-bit flop with reset, preset and enable, honouring ASYNC_PRESET_EN) SHALL be instantiated WIDTH times by a generate loop.
REQ-030 The change-detect logic SHALL reside in the top level.

Verification
REQ-031 WIDTH=1, reset_in=1 for 2 edges -> q_out=0, qn_out=1; chg_out=0 on the second edge.
REQ-032 reset_in=0, preset_in=1, one edge -> q_out=1, chg_out=1; further edges with preset_in=1 -> q_out=1, chg_out=0.
REQ-033 reset_in=1 and preset_in=1 together -> q_out=0 after the edge.
REQ-034 WIDTH=8, en_in=1, d_in=8'hA5 -> q_out=8'hA5 one edge later; then en_in=0, d_in=8'h3C -> q_out holds 8'hA5.
REQ-035 d_in toggling every 7 time units with clk period 20 -> q_out changes only at rising clk edges.
REQ-036 ASYNC_PRESET_EN defined, preset_in rises mid-cycle -> q_out=PRESET_VAL before the next edge; ASYNC_PRESET_EN undefined -> q_out unchanged until the edge.

Source files
------------

// File: rtl/d_ff_pet_pkg.sv
// rtl/d_ff_pet_pkg.sv - shared width limit and default load values for the d_ff_pet flop family
package d_ff_pet_pkg;

  localparam int MAX_WIDTH = 64;

  localparam logic [MAX_WIDTH-1:0] DEFAULT_RESET_VAL  = '0;
  localparam logic [MAX_WIDTH-1:0] DEFAULT_PRESET_VAL = '1;

endpackage

// File: rtl/d_ff_pet_cell.sv
// rtl/d_ff_pet_cell.sv - 1-bit flop with sync reset, preset (async when ASYNC_PRESET_EN) and enable
module d_ff_pet_cell #(
  parameter logic RESET_BIT  = 1'b0,
  parameter logic PRESET_BIT = 1'b1
) (
  input  logic clk,
  input  logic reset_in,
  input  logic preset_in,
  input  logic en_in,
  input  logic d_in,
  output logic q_out
);

`ifdef ASYNC_PRESET_EN
  // Preset rising loads immediately; a clock edge with reset still dominates.
  always_ff @(posedge clk or posedge preset_in) begin
    if (reset_in) begin
      q_out <= RESET_BIT;
    end else if (preset_in) begin
      q_out <= PRESET_BIT;
    end else if (en_in) begin
      q_out <= d_in;
    end
  end
`else
  // Fixed priority load at the clock edge: reset, preset, data, hold.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      q_out <= RESET_BIT;
    end else if (preset_in) begin
      q_out <= PRESET_BIT;
    end else if (en_in) begin
      q_out <= d_in;
    end
  end
`endif

endmodule

// File: rtl/d_ff_pet_reset_preset.sv
// rtl/d_ff_pet_reset_preset.sv - WIDTH-bit flop with reset/preset/enable, inverse and change flag; ASYNC_PRESET_EN selects async preset
module d_ff_pet_reset_preset
  import d_ff_pet_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = DEFAULT_RESET_VAL[WIDTH-1:0],
  parameter logic [WIDTH-1:0] PRESET_VAL = DEFAULT_PRESET_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             preset_in,
  input  logic             en_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] qn_out,
  output logic             chg_out
);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_seen;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_pet_cell #(
      .RESET_BIT  (RESET_VAL[i]),
      .PRESET_BIT (PRESET_VAL[i])
    ) u_cell (
      .clk       (clk),
      .reset_in  (reset_in),
      .preset_in (preset_in),
      .en_in     (en_in),
      .d_in      (d_in[i]),
      .q_out     (q_out[i])
    );
  end

  assign qn_out = ~q_out;

  // Value the cells will hold after the coming edge, same priority as the cells.
  always_comb begin
    q_next = q_out;
    if (reset_in) begin
      q_next = RESET_VAL;
    end else if (preset_in) begin
      q_next = PRESET_VAL;
    end else if (en_in) begin
      q_next = d_in;
    end
  end

  // Compare against the value seen at the previous edge so an asynchronous
  // preset between edges is still reported, but only at the next clock edge.
  always_ff @(posedge clk) begin
    q_seen  <= q_next;
    chg_out <= (q_next != q_seen);
  end

endmodule

// File: tb/tb_d_ff_pet_reset_preset.sv
// tb/tb_d_ff_pet_reset_preset.sv - directed vector bench for d_ff_pet_reset_preset (WIDTH 1 and 8)
module tb_d_ff_pet_reset_preset;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic       preset_in = 1'b0;
  logic       en_in = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic       d1;
  logic [7:0] q8, qn8;
  logic       q1, qn1;
  logic       chg8, chg1;

  int tests = 0;
  int fails = 0;

  assign d1 = d8[0];

  always #10 clk = ~clk;

  d_ff_pet_reset_preset #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset_in  (reset_in),
    .preset_in (preset_in),
    .en_in     (en_in),
    .d_in      (d8),
    .q_out     (q8),
    .qn_out    (qn8),
    .chg_out   (chg8)
  );

  d_ff_pet_reset_preset #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .reset_in  (reset_in),
    .preset_in (preset_in),
    .en_in     (en_in),
    .d_in      (d1),
    .q_out     (q1),
    .qn_out    (qn1),
    .chg_out   (chg1)
  );

  typedef struct {
    logic       rst;
    logic       pre;
    logic       en;
    logic [7:0] d;
    logic [7:0] q8;
    logic       chg8;
    logic       q1;
    logic       chg1;
    logic       chk_chg;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //         rst   pre   en    d      q8     chg8  q1    chg1  chk_chg
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      reset_in  = vecs[i].rst;
      preset_in = vecs[i].pre;
      en_in     = vecs[i].en;
      d8        = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("v%0d q8", i), q8, vecs[i].q8);
      check($sformatf("v%0d qn8", i), qn8, ~vecs[i].q8);
      check($sformatf("v%0d q1", i), {7'b0, q1}, {7'b0, vecs[i].q1});
      check($sformatf("v%0d qn1", i), {7'b0, qn1}, {7'b0, ~vecs[i].q1});
      if (vecs[i].chk_chg) begin
        check($sformatf("v%0d chg8", i), {7'b0, chg8}, {7'b0, vecs[i].chg8});
        check($sformatf("v%0d chg1", i), {7'b0, chg1}, {7'b0, vecs[i].chg1});
      end
    end

    // Load A5, then assert reset between edges: no effect until the edge.
    @(negedge clk);
    en_in = 1'b1;
    d8    = 8'hA5;
    @(posedge clk);
    #1;
    check("load_a5 q8", q8, 8'hA5);
    @(negedge clk);
    en_in    = 1'b0;
    reset_in = 1'b1;
    #5;
    check("midcycle_reset q8", q8, 8'hA5);
    @(posedge clk);
    #1;
    check("reset_edge q8", q8, 8'h00);
    check("reset_edge chg8", {7'b0, chg8}, 8'h01);

    // d toggles every 7 units while enabled; q must only move at edges.
    @(negedge clk);
    reset_in = 1'b0;
    en_in    = 1'b1;
    d8       = 8'h0F;
    fork
      begin
        repeat (9) begin
          #7;
          d8 = ~d8;
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          check($sformatf("toggle%0d early q8", k), q8, (k == 1) ? 8'h0F : 8'hF0);
          #8;
          check($sformatf("toggle%0d late q8", k), q8, (k == 1) ? 8'h0F : 8'hF0);
        end
      end
    join

    // Preset rising between edges: async build loads at once, sync build waits.
    @(negedge clk);
    en_in = 1'b0;
    d8    = 8'h00;
    @(posedge clk);
    #1;
    check("pre_setup q8", q8, 8'hF0);
    #4;
    preset_in = 1'b1;
    #2;
`ifdef ASYNC_PRESET_EN
    check("midcycle_preset q8", q8, 8'hFF);
`else
    check("midcycle_preset q8", q8, 8'hF0);
`endif
    @(posedge clk);
    #1;
    check("preset_edge q8", q8, 8'hFF);
    check("preset_edge qn8", qn8, 8'h00);

    @(negedge clk);
    preset_in = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
